// File: rtl/p_encoder_queued_if.sv
// p_encoder_queued_if -- request/index bus for p_encoder_queued.
//   master : request source + consumer side (drives d_in, clr, out_ready)
//   slave  : encoder side (drives out_valid, out_idx, pending, overflow)
// Signals:
//   d_in[N-1:0]     request pulses
//   clr             synchronous flush of pending requests and overflow
//   out_ready       consumer accepts out_idx this cycle
//   out_valid       at least one request pending
//   out_idx[W-1:0]  selected pending request
//   pending[N-1:0]  pending-request register
//   overflow        sticky: request arrived on an already-pending line
interface p_encoder_queued_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] d_in;
  logic         clr;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] pending;
  logic         overflow;

  modport master (
    output d_in, clr, out_ready,
    input  out_valid, out_idx, pending, overflow
  );

  modport slave (
    input  d_in, clr, out_ready,
    output out_valid, out_idx, pending, overflow
  );
endinterface

// File: rtl/p_encoder_queued.sv
// p_encoder_queued -- registered N-to-log2(N) priority encoder with a
// pending-request register and valid/ready index output.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : p_encoder_queued_if.slave (d_in, clr, out_ready in;
//          out_valid, out_idx, pending, overflow out)
// Build option: define P_ENCODER_ROUND_ROBIN_EN for rotating priority
// (search descends from ptr with wrap-around). Default build uses fixed
// priority, highest index wins.
// All outputs are decoded from registered state only; d_in and out_ready
// affect next state only.
module p_encoder_queued #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  p_encoder_queued_if.slave   bus
);

  logic [N-1:0] pending_q;
  logic         overflow_q;
  logic [W-1:0] sel;
  logic [N-1:0] grant;
  logic         fire;

`ifdef P_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q;
  logic [W-1:0] rr_pos;

  // Walk offsets from farthest to nearest so the last hit (the first bit
  // found descending from ptr) is the one that sticks.
  always_comb begin
    sel    = '0;
    rr_pos = '0;
    for (int off = N - 1; off >= 0; off--) begin
      rr_pos = W'((int'(ptr_q) + N - off) % N);
      if (pending_q[rr_pos]) sel = rr_pos;
    end
  end
`else
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) sel = W'(i);
    end
  end
`endif

  assign fire = (|pending_q) & bus.out_ready & ~bus.clr;

  always_comb begin
    grant = '0;
    if (fire) grant[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else if (bus.clr) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q <= (pending_q & ~grant) | bus.d_in;
      // A re-request on the bit being granted is a fresh request, not a loss.
      if (|(bus.d_in & pending_q & ~grant)) overflow_q <= 1'b1;
    end
  end

`ifdef P_ENCODER_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= W'(N - 1);
    end else if (bus.clr) begin
      ptr_q <= W'(N - 1);
    end else if (fire) begin
      ptr_q <= (sel == '0) ? W'(N - 1) : sel - 1'b1;
    end
  end
`endif

  assign bus.out_valid = |pending_q;
  assign bus.out_idx   = sel;
  assign bus.pending   = pending_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_p_encoder_queued.sv
module tb_p_encoder_queued;

  localparam int N = 8;

  logic clk;
  logic rst;

  p_encoder_queued_if #(.N(N)) bus ();

  p_encoder_queued #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] d_in;
    logic       clr;
    logic       rdy;
    logic       exp_valid;
    logic [2:0] exp_idx;
    logic [7:0] exp_pending;
    logic       exp_overflow;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [2:0] idx,
                           input logic [7:0] pnd, input logic ovf);
    chk({tag, ".valid"},    32'(bus.out_valid), 32'(v));
    chk({tag, ".idx"},      32'(bus.out_idx),   32'(idx));
    chk({tag, ".pending"},  32'(bus.pending),   32'(pnd));
    chk({tag, ".overflow"}, 32'(bus.overflow),  32'(ovf));
  endtask

  task automatic step(input logic [7:0] d, input logic c, input logic r);
    @(negedge clk);
    bus.d_in      = d;
    bus.clr       = c;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          d_in   clr  rdy  valid idx  pending  ovf
    vecs[0]  = '{8'h52, 1'b0, 1'b1, 1'b1, 3'd6, 8'h52, 1'b0}; // drain order
    vecs[1]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd4, 8'h12, 1'b0};
    vecs[2]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd1, 8'h02, 1'b0};
    vecs[3]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[4]  = '{8'h10, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0}; // preemption
    vecs[5]  = '{8'h80, 1'b0, 1'b0, 1'b1, 3'd7, 8'h90, 1'b0};
    vecs[6]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd4, 8'h10, 1'b0};
    vecs[7]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[8]  = '{8'h04, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0}; // overflow
    vecs[9]  = '{8'h04, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 1'b1};
    vecs[10] = '{8'h01, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0}; // clr drops d_in
    vecs[11] = '{8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0}; // collision
    vecs[12] = '{8'h08, 1'b0, 1'b1, 1'b1, 3'd3, 8'h08, 1'b0};
    vecs[13] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[14] = '{8'h01, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0}; // index 0 valid
    vecs[15] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[16] = '{8'hC0, 1'b0, 1'b0, 1'b1, 3'd7, 8'hC0, 1'b0}; // clr beats grant
    vecs[17] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0};

    bus.d_in      = '0;
    bus.clr       = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    #12;
    check_all("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].d_in, vecs[i].clr, vecs[i].rdy);
      check_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_idx,
                vecs[i].exp_pending, vecs[i].exp_overflow);
    end

    // Fairness: 8'h82 every cycle with out_ready high.
    step(8'h82, 1'b0, 1'b1);
    chk("fair0.idx", 32'(bus.out_idx), 32'd7);
    for (int c = 1; c < 5; c++) begin
      step(8'h82, 1'b0, 1'b1);
`ifdef P_ENCODER_ROUND_ROBIN_EN
      chk($sformatf("fair%0d.idx", c), 32'(bus.out_idx), (c % 2 == 1) ? 32'd1 : 32'd7);
`else
      chk($sformatf("fair%0d.idx", c), 32'(bus.out_idx), 32'd7);
`endif
      chk($sformatf("fair%0d.pending", c), 32'(bus.pending), 32'h82);
    end
    step(8'h00, 1'b1, 1'b0);
    check_all("fair_clr", 1'b0, 3'd0, 8'h00, 1'b0);

    // Asynchronous reset mid-stream with everything pending and overflow set.
    step(8'hFF, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b0);
    check_all("fill", 1'b1, 3'd7, 8'hFF, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    bus.d_in = '0;
    rst      = 1'b0;

    // After reset, selection matches fixed priority again.
    step(8'h24, 1'b0, 1'b0);
    check_all("post_rst", 1'b1, 3'd5, 8'h24, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/p_encoder_queued.md
# p_encoder_queued

Parametrised, registered N-to-log2(N) priority encoder with a pending-request register. It captures request pulses on any of N lines, holds them until served, and presents one index per accepted transfer on a valid/ready output. It sits between interrupt/event sources and a single consumer, replacing the combinational 4-to-2 encoder wherever requests are short pulses or the consumer can stall. Priority is fixed (highest index wins), or rotating when the round-robin build option is compiled in.

## Interface
- N, default 8: number of request lines, ≥2.
- W, derived as $clog2(N): index width; not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- d_in  in  N  request pulses; bit i high for one cycle registers request i.
- clr  in  1  synchronous flush of all pending requests and the overflow flag.
- out_ready  in  1  consumer accepts the current index.
- out_valid  out  1  at least one request is pending.
- out_idx  out  W  index of the selected pending request.
- pending  out  N  current pending-request register.
- overflow  out  1  sticky flag: a request arrived on an already-pending line.

## Operation
- State: pending[N-1:0], overflow, and ptr[W-1:0] (round-robin builds only).
- out_valid = |pending. out_idx is selected from the pending register only, never from d_in.
- Fixed priority: out_idx is the highest set index of pending. When pending = 0, out_idx = 0.
- A grant occurs when out_valid & out_ready. The granted bit is cleared in the same edge.
- Next state: pending ← (pending & ~grant_onehot) | d_in.
- If d_in[k] is high on the same edge that bit k is granted, bit k stays set. This is a new request and does not set overflow.
- overflow is set when d_in[i] & pending[i] & ~grant_onehot[i] for any i. It stays set until clr or rst.
- clr takes precedence over everything: pending ← 0 and overflow ← 0. Any d_in asserted in that cycle is dropped, and no grant is counted even if out_ready is high.
- out_idx may change while out_valid=1 and out_ready=0, for example when a higher-priority request preempts. The consumer samples the index only on the acceptance cycle.
- N not a power of two: indices ≥N never appear.

## Timing
- Reset values: pending=0, overflow=0, out_valid=0, out_idx=0, ptr=N-1.
- Latency: a request on d_in at edge t is visible on out_valid/out_idx after edge t (one cycle). There is no combinational path from d_in to any output.
- out_ready affects only the next state. No combinational path from out_ready to the outputs.
- Throughput: one grant per cycle with out_ready held high.
- Reset asserted mid-operation clears all state immediately, independent of clk. Requests in flight are lost.

## Configuration
- Macro: P_ENCODER_ROUND_ROBIN_EN.
- Defined:
  - The search starts at ptr and descends with wrap-around (ptr, ptr-1, …, 0, N-1, …). The first set bit found is out_idx.
  - On a grant of index k, ptr ← (k==0 ? N-1 : k-1).
  - clr also resets ptr to N-1.
  - The first selection after reset matches fixed priority.
- Undefined: ptr does not exist; priority is fixed, highest index wins. All other behaviour is identical.

## Test plan
- Reset: assert rst asynchronously mid-stream with pending=8'hFF → pending=0, out_valid=0, out_idx=0, overflow=0 before the next clk edge.
- Drain order (N=8): d_in=8'b0101_0010 for one cycle, out_ready=1 → out_idx 6, 4, 1 on three consecutive cycles with out_valid=1, then out_valid=0.
- Preemption/stall: out_ready=0, d_in=8'h10 then 8'h80 → out_idx=4, then 7. Raise out_ready → grants 7, then 4.
- Overflow and clr: out_ready=0, d_in=8'h04 on two consecutive cycles → overflow=1 after the second edge. Then clr with d_in=8'h01 → pending=0, overflow=0, out_valid=0.
- Grant/re-request collision: pending=8'h08, out_ready=1, d_in=8'h08 in the same cycle → pending stays 8'h08, overflow stays 0.
- Fairness: d_in=8'h82 every cycle, out_ready=1 → with the macro, out_idx alternates 7, 1, 7, 1. Without the macro, out_idx is 7 every cycle and bit 1 remains pending.
